// File: rtl/fetch_stage.sv
// Instruction fetch front end: issues sequential word reads, queues returns, hands {pc, instr, fault} downstream.
// Latency: response in cycle N is visible on down_* in cycle N+1.
// Backpressure: issue stalls while in-flight requests plus queued entries reach DEPTH; responses are always accepted.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_error,
    output logic        down_valid,
    input  logic        down_ready,
    output logic [31:0] down_pc,
    output logic [31:0] down_instr,
    output logic        down_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t        CNT_ONE = cnt_t'(1);
    localparam ptr_t        PTR_ONE = ptr_t'(1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0] pc_q, pc_d;
    cnt_t        inflight_q, inflight_d;
    cnt_t        drop_q, drop_d;
    cnt_t        fifo_cnt_q, fifo_cnt_d;
    logic        halted_q, halted_d;
    ptr_t        fifo_rd_q, fifo_rd_d;
    ptr_t        fifo_wr_q, fifo_wr_d;
    ptr_t        pcq_rd_q, pcq_rd_d;
    ptr_t        pcq_wr_q, pcq_wr_d;

    logic [31:0] pcq_addr_q   [DEPTH];
    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];
    logic        fifo_fault_q [DEPTH];

    logic [CW:0] occupancy;
    logic        req_fire;
    logic        rsp_discard;
    logic        push;
    logic        pop;

    // Queued entries and in-flight requests share one credit pool so a return always has a slot.
    assign occupancy     = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign mem_req_valid = !reset && !halted_q && !redirect_valid && (occupancy < DEPTH_W);
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_discard   = mem_rsp_valid && ((drop_q != '0) || redirect_valid);
    assign push          = mem_rsp_valid && !rsp_discard;

    assign down_valid    = !reset && (fifo_cnt_q != '0);
    assign down_pc       = fifo_pc_q[fifo_rd_q];
    assign down_instr    = fifo_instr_q[fifo_rd_q];
    assign down_fault    = fifo_fault_q[fifo_rd_q];
    assign pop           = down_valid && down_ready;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        fifo_cnt_d = fifo_cnt_q;
        halted_d   = halted_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        pcq_rd_d   = pcq_rd_q;
        pcq_wr_d   = pcq_wr_q;

        if (req_fire) begin
            pc_d       = pc_q + 32'd4;
            inflight_d = inflight_d + CNT_ONE;
            pcq_wr_d   = pcq_wr_q + PTR_ONE;
        end

        // Every response retires its PC-queue slot, kept or discarded, so the queue tracks inflight.
        if (mem_rsp_valid) begin
            inflight_d = inflight_d - CNT_ONE;
            pcq_rd_d   = pcq_rd_q + PTR_ONE;
        end

        if (rsp_discard && (drop_q != '0))
            drop_d = drop_q - CNT_ONE;

        if (push) begin
            fifo_wr_d  = fifo_wr_q + PTR_ONE;
            fifo_cnt_d = fifo_cnt_d + CNT_ONE;
        end

        if (pop) begin
            fifo_rd_d  = fifo_rd_q + PTR_ONE;
            fifo_cnt_d = fifo_cnt_d - CNT_ONE;
        end

        // A fault stops fetch; everything still outstanding, including a same-cycle request, is stale.
        if (push && mem_rsp_error) begin
            halted_d = 1'b1;
            drop_d   = inflight_d;
        end

        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            fifo_cnt_d = '0;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            halted_d   = 1'b0;
            drop_d     = inflight_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            fifo_cnt_q <= '0;
            halted_q   <= 1'b0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fifo_cnt_q <= fifo_cnt_d;
            halted_q   <= halted_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (req_fire)
            pcq_addr_q[pcq_wr_q] <= pc_q;
        if (push) begin
            fifo_pc_q[fifo_wr_q]    <= pcq_addr_q[pcq_rd_q];
            fifo_instr_q[fifo_wr_q] <= mem_rsp_error ? 32'h0 : mem_rsp_data;
            fifo_fault_q[fifo_wr_q] <= mem_rsp_error;
        end
    end

    rsp_without_request: assert property (@(posedge clock) disable iff (reset)
        mem_rsp_valid |-> (inflight_q != '0));

    fifo_no_overflow: assert property (@(posedge clock) disable iff (reset)
        (push && !pop) |-> (fifo_cnt_q < cnt_t'(DEPTH)));

    inflight_bounded: assert property (@(posedge clock) disable iff (reset)
        inflight_q <= cnt_t'(DEPTH));

endmodule
